// File: rtl/fetch_stage_if.sv
// Instruction-memory read port used by the fetch stage: a single outstanding
// request held with a fixed address until a one-cycle ack returns the word.
interface fetch_stage_if #(
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches one word at a time from instruction memory and
// presents it to the fetch/decode register, honouring stall and branch redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallF,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    fetch_stage_if.master     imem,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic [31:0]       inst_pc,
    output logic [31:0]       pc_plus4
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t            state;
    logic [31:0]       pc;
    logic [31:0]       drop_addr;
    logic [DATA_W-1:0] skid;
    logic [31:0]       skid_pc;
    logic [31:0]       target;

    assign target   = {branch_target[31:2], 2'b00};
    assign pc_plus4 = inst_pc + 32'd4;

    // The request stays up in DROP so the abandoned read can complete and be discarded.
    assign imem.imem_req  = (state != HOLD);
    assign imem.imem_addr = (state == DROP) ? drop_addr : pc;

    // NOTE: every register, including the skid buffer, is cleared by the async
    // reset and updated with non-blocking assignments so all state moves together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drop_addr  <= RESET_PC;
            skid       <= '0;
            skid_pc    <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            inst_pc    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                        if (!imem.imem_ack) begin
                            drop_addr <= pc;
                            state     <= DROP;
                        end
                    end else if (imem.imem_ack) begin
                        if (!inst_valid || !stallF) begin
                            inst_out   <= imem.imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                        end else begin
                            skid    <= imem.imem_rdata;
                            skid_pc <= pc;
                            state   <= HOLD;
                        end
                        pc <= pc + 32'd4;
                    end else if (inst_valid && !stallF) begin
                        inst_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end else if (!stallF) begin
                        inst_out   <= skid;
                        inst_pc    <= skid_pc;
                        inst_valid <= 1'b1;
                        state      <= FETCH;
                    end
                end
                DROP: begin
                    inst_valid <= 1'b0;
                    if (branch_taken) begin
                        pc <= target;
                    end
                    if (imem.imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small latency-programmable memory model
// answers requests while each task checks one scenario cycle by cycle.
module tb_fetch_stage;
    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;

    fetch_stage_if #(.DATA_W(32)) bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .stallF       (stallF),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem         (bus.master),
        .inst_out     (inst_out),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
        .pc_plus4     (pc_plus4)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 0;
    bit mem_en      = 1'b1;
    int cnt         = 0;

    // Memory answers the current request once it has waited lat cycles.
    task automatic mem_update();
        bus.imem_ack   = mem_en && bus.imem_req && (cnt >= lat);
        bus.imem_rdata = bus.imem_ack ? (bus.imem_addr ^ PAT) : 32'h0;
    endtask

    task automatic step();
        logic a, r;
        a = bus.imem_ack;
        r = bus.imem_req;
        @(posedge clk);
        if (a) cnt = 0;
        else if (r) cnt++;
        #1;
        mem_update();
    endtask

    task automatic apply_reset();
        reset = 1'b1; stallF = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        mem_en = 1'b1; lat = 0; cnt = 0;
        mem_update();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; cnt = 0;
        mem_update();
    endtask

    task automatic test_reset();
        reset = 1'b1; stallF = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        mem_en = 1'b1; lat = 0; cnt = 0;
        #1;
        mem_update();
        vectors++; if (inst_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", inst_valid); miscompares++; end
        vectors++; if (inst_out !== 32'h0) begin $display("FAIL reset_inst_out got %h exp 0", inst_out); miscompares++; end
        vectors++; if (inst_pc !== 32'h0) begin $display("FAIL reset_inst_pc got %h exp 0", inst_pc); miscompares++; end
        vectors++; if (pc_plus4 !== 32'h4) begin $display("FAIL reset_pc_plus4 got %h exp 4", pc_plus4); miscompares++; end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; cnt = 0;
        mem_update();
        vectors++; if (bus.imem_req !== 1'b1) begin $display("FAIL release_req got %b exp 1", bus.imem_req); miscompares++; end
        vectors++; if (bus.imem_addr !== 32'h0) begin $display("FAIL release_addr got %h exp 0", bus.imem_addr); miscompares++; end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            e = 32'(4 * i);
            vectors++; if (inst_valid !== 1'b1) begin $display("FAIL stream_valid[%0d] got %b exp 1", i, inst_valid); miscompares++; end
            vectors++; if (inst_pc !== e) begin $display("FAIL stream_pc[%0d] got %h exp %h", i, inst_pc, e); miscompares++; end
            vectors++; if (inst_out !== (e ^ PAT)) begin $display("FAIL stream_inst[%0d] got %h exp %h", i, inst_out, e ^ PAT); miscompares++; end
            vectors++; if (bus.imem_addr !== e + 32'd4) begin $display("FAIL stream_addr[%0d] got %h exp %h", i, bus.imem_addr, e + 32'd4); miscompares++; end
            vectors++; if (pc_plus4 !== e + 32'd4) begin $display("FAIL stream_pc4[%0d] got %h exp %h", i, pc_plus4, e + 32'd4); miscompares++; end
        end
    endtask

    task automatic test_wait3();
        logic        ev;
        logic [31:0] epc, eaddr;
        apply_reset();
        lat = 3;
        mem_update();
        for (int k = 1; k <= 16; k++) begin
            step();
            ev    = (k % 4 == 0);
            eaddr = 32'((k / 4) * 4);
            epc   = 32'((k / 4 - 1) * 4);
            vectors++; if (inst_valid !== ev) begin $display("FAIL wait_valid[%0d] got %b exp %b", k, inst_valid, ev); miscompares++; end
            vectors++; if (bus.imem_addr !== eaddr) begin $display("FAIL wait_addr[%0d] got %h exp %h", k, bus.imem_addr, eaddr); miscompares++; end
            if (ev) begin
                vectors++; if (inst_pc !== epc) begin $display("FAIL wait_pc[%0d] got %h exp %h", k, inst_pc, epc); miscompares++; end
            end
        end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        step();
        step();
        stallF = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            vectors++; if (bus.imem_req !== 1'b0) begin $display("FAIL hold_req[%0d] got %b exp 0", i, bus.imem_req); miscompares++; end
            vectors++; if (inst_valid !== 1'b1) begin $display("FAIL hold_valid[%0d] got %b exp 1", i, inst_valid); miscompares++; end
            vectors++; if (inst_pc !== 32'h4) begin $display("FAIL hold_pc[%0d] got %h exp 4", i, inst_pc); miscompares++; end
            vectors++; if (inst_out !== (32'h4 ^ PAT)) begin $display("FAIL hold_inst[%0d] got %h exp %h", i, inst_out, 32'h4 ^ PAT); miscompares++; end
            step();
        end
        stallF = 1'b0;
        step();
        vectors++; if (inst_pc !== 32'h8) begin $display("FAIL unhold_pc got %h exp 8", inst_pc); miscompares++; end
        vectors++; if (inst_out !== (32'h8 ^ PAT)) begin $display("FAIL unhold_inst got %h exp %h", inst_out, 32'h8 ^ PAT); miscompares++; end
        vectors++; if (inst_valid !== 1'b1) begin $display("FAIL unhold_valid got %b exp 1", inst_valid); miscompares++; end
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin $display("FAIL unhold_req got %b/%h exp 1/c", bus.imem_req, bus.imem_addr); miscompares++; end
    endtask

    task automatic test_branch_drop();
        apply_reset();
        repeat (4) step();
        lat = 2; cnt = 0;
        mem_update();
        vectors++; if (bus.imem_addr !== 32'h10) begin $display("FAIL drop_pre_addr got %h exp 10", bus.imem_addr); miscompares++; end
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin $display("FAIL drop_addr[%0d] got %b/%h exp 1/10", i, bus.imem_req, bus.imem_addr); miscompares++; end
            vectors++; if (inst_valid !== 1'b0) begin $display("FAIL drop_valid[%0d] got %b exp 0", i, inst_valid); miscompares++; end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.imem_addr !== 32'h100) begin $display("FAIL redirect_addr[%0d] got %h exp 100", i, bus.imem_addr); miscompares++; end
            vectors++; if (inst_valid !== 1'b0) begin $display("FAIL redirect_valid[%0d] got %b exp 0", i, inst_valid); miscompares++; end
            step();
        end
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin $display("FAIL target_inst got %b/%h exp 1/100", inst_valid, inst_pc); miscompares++; end
        vectors++; if (inst_out !== (32'h100 ^ PAT)) begin $display("FAIL target_data got %h exp %h", inst_out, 32'h100 ^ PAT); miscompares++; end
    endtask

    task automatic test_branch_ack();
        apply_reset();
        step();
        stallF = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        branch_taken = 1'b0; stallF = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin $display("FAIL bra_valid got %b exp 0", inst_valid); miscompares++; end
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin $display("FAIL bra_addr got %b/%h exp 1/200", bus.imem_req, bus.imem_addr); miscompares++; end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin $display("FAIL bra_next got %b/%h exp 1/200", inst_valid, inst_pc); miscompares++; end
    endtask

    task automatic test_reset_midwait();
        apply_reset();
        step();
        stallF = 1'b1; mem_en = 1'b0;
        mem_update();
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin $display("FAIL stall_keep got %b/%h exp 1/0", inst_valid, inst_pc); miscompares++; end
        vectors++; if (bus.imem_addr !== 32'h4) begin $display("FAIL stall_addr got %h exp 4", bus.imem_addr); miscompares++; end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (inst_valid !== 1'b0) begin $display("FAIL async_valid got %b exp 0", inst_valid); miscompares++; end
        vectors++; if (inst_out !== 32'h0) begin $display("FAIL async_inst got %h exp 0", inst_out); miscompares++; end
        vectors++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin $display("FAIL async_addr got %b/%h exp 1/0", bus.imem_req, bus.imem_addr); miscompares++; end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_pre got %h exp fffffffc", bus.imem_addr); miscompares++; end
        step();
        vectors++; if (inst_pc !== 32'hFFFF_FFFC || inst_valid !== 1'b1) begin $display("FAIL wrap_inst got %b/%h exp 1/fffffffc", inst_valid, inst_pc); miscompares++; end
        vectors++; if (bus.imem_addr !== 32'h0) begin $display("FAIL wrap_addr got %h exp 0", bus.imem_addr); miscompares++; end
        vectors++; if (pc_plus4 !== 32'h0) begin $display("FAIL wrap_pc4 got %h exp 0", pc_plus4); miscompares++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stallF = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_wait3();
        test_stall_hold();
        test_branch_drop();
        test_branch_ack();
        test_reset_midwait();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
